// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the decode-to-execute pipeline stage register:
// control polarities, stage occupancy encoding and the NOP bundle.
package pipe_stage_reg_pkg;

   localparam logic RST_ACTIVE  = 1'b1;
   localparam logic HOLD_ACTIVE = 1'b1;
   localparam logic JUMP_ACTIVE = 1'b1;

   localparam int BUNDLE_W = 146;
   localparam logic [BUNDLE_W-1:0] NOP_BUNDLE = {BUNDLE_W{1'b0}};

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } stage_state_e;

   // A stall cycle is a presented payload that downstream refuses, or a system pause.
   function automatic logic stall_cond(input logic valid_int, input logic ready_dn, input logic hold);
      return (valid_int && !ready_dn) || hold;
   endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter; clr has priority over inc and the count never wraps.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk_100MHz,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_r;

   // Count register, held at all-ones once reached.
   always_ff @(posedge clk_100MHz) begin
      if (clr) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (inc && (cnt_r != {CNT_W{1'b1}})) begin
         cnt_r <= cnt_r + CNT_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign cnt = cnt_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage with hold, flush and a saturating stall counter.
// Define PIPE_SKID_EN for a registered ready_o backed by a second skid register.
module pipe_stage_reg
   import pipe_stage_reg_pkg::*;
#(
   parameter int                DATA_W  = 146,
   parameter logic [DATA_W-1:0] RST_VAL = DATA_W'(NOP_BUNDLE),
   parameter int                CNT_W   = 16
) (
   input  logic              clk_100MHz,
   input  logic              rst,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [DATA_W-1:0] data_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [DATA_W-1:0] data_o,
   input  logic              hold_i,
   input  logic              flush_i,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   logic rst_s;
   logic hold_s;
   logic flush_s;
   logic valid_int_s;
   logic in_xfer_s;
   logic out_xfer_s;

   assign rst_s   = (rst == RST_ACTIVE);
   assign hold_s  = (hold_i == HOLD_ACTIVE);
   assign flush_s = (flush_i == JUMP_ACTIVE);

   // Reset masks valid_o so nothing leaves the stage while it is being cleared.
   assign valid_o    = valid_int_s && !hold_s && !rst_s;
   assign out_xfer_s = valid_o && ready_i;
   assign in_xfer_s  = valid_i && ready_o;

`ifdef PIPE_SKID_EN
   stage_state_e      state_r;
   stage_state_e      state_nxt_s;
   logic [DATA_W-1:0] data_r;
   logic [DATA_W-1:0] data_nxt_s;
   logic [DATA_W-1:0] skid_r;
   logic [DATA_W-1:0] skid_nxt_s;
   logic              ready_r;

   assign valid_int_s = (state_r != ST_EMPTY);
   assign ready_o     = ready_r && !hold_s && !flush_s && !rst_s;
   assign data_o      = data_r;

   // Occupancy next-state; hold needs no branch since it already blocks both transfers.
   always_comb begin
      state_nxt_s = state_r;
      data_nxt_s  = data_r;
      skid_nxt_s  = skid_r;
      if (flush_s) begin
         state_nxt_s = ST_EMPTY;
         data_nxt_s  = RST_VAL;
         skid_nxt_s  = RST_VAL;
      end else begin
         case (state_r)
            ST_EMPTY: begin
               if (in_xfer_s) begin
                  state_nxt_s = ST_ONE;
                  data_nxt_s  = data_i;
               end else begin
                  state_nxt_s = ST_EMPTY;
               end
            end
            ST_ONE: begin
               if (in_xfer_s && out_xfer_s) begin
                  data_nxt_s = data_i;
               end else if (in_xfer_s) begin
                  state_nxt_s = ST_TWO;
                  skid_nxt_s  = data_i;
               end else if (out_xfer_s) begin
                  state_nxt_s = ST_EMPTY;
               end else begin
                  state_nxt_s = ST_ONE;
               end
            end
            ST_TWO: begin
               if (out_xfer_s) begin
                  state_nxt_s = ST_ONE;
                  data_nxt_s  = skid_r;
               end else begin
                  state_nxt_s = ST_TWO;
               end
            end
            default: begin
               state_nxt_s = ST_EMPTY;
               data_nxt_s  = RST_VAL;
               skid_nxt_s  = RST_VAL;
            end
         endcase
      end
   end

   // State and payload registers; ready_r is the registered "skid empty" flag.
   always_ff @(posedge clk_100MHz) begin
      if (rst_s) begin
         state_r <= ST_EMPTY;
         data_r  <= RST_VAL;
         skid_r  <= RST_VAL;
         ready_r <= 1'b1;
      end else begin
         state_r <= state_nxt_s;
         data_r  <= data_nxt_s;
         skid_r  <= skid_nxt_s;
         ready_r <= (state_nxt_s != ST_TWO);
      end
   end
`else
   logic              valid_r;
   logic              valid_nxt_s;
   logic [DATA_W-1:0] data_r;
   logic [DATA_W-1:0] data_nxt_s;

   assign valid_int_s = valid_r;
   assign ready_o     = !hold_s && !flush_s && !rst_s && (!valid_r || ready_i);
   assign data_o      = data_r;

   // Single-register next-state: flush empties, input replaces, output drains.
   always_comb begin
      valid_nxt_s = valid_r;
      data_nxt_s  = data_r;
      if (flush_s) begin
         valid_nxt_s = 1'b0;
         data_nxt_s  = RST_VAL;
      end else if (in_xfer_s) begin
         valid_nxt_s = 1'b1;
         data_nxt_s  = data_i;
      end else if (out_xfer_s) begin
         valid_nxt_s = 1'b0;
      end else begin
         valid_nxt_s = valid_r;
      end
   end

   // Payload register.
   always_ff @(posedge clk_100MHz) begin
      if (rst_s) begin
         valid_r <= 1'b0;
         data_r  <= RST_VAL;
      end else begin
         valid_r <= valid_nxt_s;
         data_r  <= data_nxt_s;
      end
   end
`endif

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk_100MHz (clk_100MHz),
      .clr        (rst_s),
      .inc        (stall_cond(valid_int_s, ready_i, hold_s)),
      .cnt        (stall_cnt_o)
   );

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The module SHALL have parameter DATA_W, default 146, meaning payload width in bits (the full decode-to-execute bundle).
REQ-002 The module SHALL have parameter RST_VAL, default all-zero, meaning the payload value driven after reset or flush (a NOP bundle).
REQ-003 The module SHALL have parameter CNT_W, default 16, meaning the stall-counter width.
REQ-004 The module SHALL have port clk_100MHz, input, 1, the single clock; all logic is on its rising edge.
REQ-005 The module SHALL have port rst, input, 1, the synchronous active-high reset.
REQ-006 The module SHALL have port valid_i, input, 1, meaning the upstream payload is valid.
REQ-007 The module SHALL have port ready_o, output, 1, meaning the stage accepts the payload this cycle.
REQ-008 The module SHALL have port data_i, input, DATA_W, the upstream payload.
REQ-009 The module SHALL have port valid_o, output, 1, meaning the downstream payload is valid.
REQ-010 The module SHALL have port ready_i, input, 1, meaning downstream accepts the payload this cycle.
REQ-011 The module SHALL have port data_o, output, DATA_W, the registered payload.
REQ-012 The module SHALL have port hold_i, input, 1, the system pause that freezes the stage.
REQ-013 The module SHALL have port flush_i, input, 1, the jump/flush request that empties the stage.
REQ-014 The module SHALL have port stall_cnt_o, output, CNT_W, the saturating count of stall cycles.

Function
REQ-015 An input transfer SHALL occur when valid_i && ready_o is true; an output transfer SHALL occur when valid_o && ready_i is true.
REQ-016 Latency SHALL be one cycle: a payload accepted in cycle N is presented on data_o with valid_o=1 in cycle N+1.
REQ-017 While valid_o=1 and ready_i=0, data_o and valid_o SHALL stay stable until the output transfer.
REQ-018 While hold_i=1, ready_o and valid_o SHALL be 0 and all internal state, including data_o, SHALL be frozen.
REQ-019 When flush_i=1 in cycle N, the stage SHALL be empty in cycle N+1: valid_o=0, data_o=RST_VAL, skid empty, and any valid_i that cycle discarded.
REQ-020 flush_i SHALL take priority over hold_i; both take priority over normal transfers.
REQ-021 A simultaneous input transfer and output transfer SHALL replace the payload with no bubble, giving full throughput.
REQ-022 stall_cnt_o SHALL increment by 1 every cycle in which (valid_o_internal && !ready_i) || hold_i is true, SHALL saturate at all-ones with no wrap, and SHALL be cleared only by rst.

Reset
REQ-023 When rst=1 at a clock edge, valid_o SHALL become 0, data_o SHALL become RST_VAL, the skid SHALL become empty and stall_cnt_o SHALL become 0.
REQ-024 ready_o SHALL be 0 during the reset cycle and SHALL become 1 in the first cycle after rst deasserts.
REQ-025 rst asserted mid-transfer SHALL drop all in-flight payloads without any output transfer.

Configuration
REQ-026 With macro PIPE_SKID_EN undefined, ready_o SHALL be the combinational function !hold_i && !flush_i && (!valid_o || ready_i), with a single payload register.
REQ-027 With PIPE_SKID_EN defined, ready_o SHALL be registered, equal to "skid empty" and gated only by hold_i and flush_i, and a second skid register SHALL be added.
REQ-028 The skid state machine SHALL have states EMPTY, ONE and TWO, with these transitions:
- EMPTY->ONE on an input transfer.
- ONE->TWO on an input transfer without an output transfer; the payload goes into the skid.
- ONE->EMPTY on an output transfer without an input transfer.
- TWO->ONE on an output transfer, with the skid payload moved to data_o.
- Any state -> EMPTY on flush_i.
REQ-029 In both builds, visible behaviour at the interface SHALL be identical apart from the timing of ready_o.

Structure
REQ-030 The stage state encoding (EMPTY/ONE/TWO) and the default RST_VAL NOP bundle constant SHALL live in the shared package, beside the existing RST/HOLD/JUMP defines.
REQ-031 The saturating stall counter SHALL be a sub-module named sat_counter, with parameter CNT_W and inputs inc and clr.

Verification
REQ-032 Scenario: rst, then valid_i=1, data_i=0x1234 with ready_i=1 -> next cycle valid_o=1 and data_o=0x1234.
REQ-033 Scenario: a stream of 8 beats with ready_i=1 throughout -> 8 output beats in 8 consecutive cycles, in order, in both builds.
REQ-034 Scenario: ready_i=0 for 5 cycles while valid_o=1 -> data_o stable and stall_cnt_o increases by 5; with PIPE_SKID_EN, exactly one extra beat is absorbed, after which ready_o=0.
REQ-035 Scenario: hold_i=1 and flush_i=1 in the same cycle, with a beat in the skid -> next cycle valid_o=0, data_o=RST_VAL and ready_o=1 once hold_i drops.
REQ-036 Scenario: CNT_W=4 with ready_i held at 0 for 20 cycles -> stall_cnt_o=15 and no wrap.
REQ-037 Scenario: rst asserted while the skid holds 2 beats -> next cycle valid_o=0 and stall_cnt_o=0, with no beat output.
